nmea_zda_framer: RTL and testbench

- Upstream stage of the GPZDA field receivers; sits between the UART byte receiver and the fixed-length field receivers.
- Recognises `$GPZDA,` sentences in the raw byte stream and splits the payload at commas into fields 0..5 (time, day, month, year, zone hour, zone minute).
- For each field it issues the `start`/`load`/`data` stimulus the field receivers consume.
- Accumulates the NMEA XOR checksum and reports sentence completion and checksum status.

---
 rtl/nmea_zda_framer.sv | 173 +++++++++++++++++
 tb/tb_nmea_zda_framer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nmea_zda_framer.sv
// Splits $GPZDA sentences into fields 0..5 and checks the NMEA XOR checksum.
// Latency: one clock from an accepted byte to its response. No backpressure: every in_valid byte is consumed.
module nmea_zda_framer #(
  parameter int B      = 8,
  parameter int MAXLEN = 15
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [B-1:0] in_data,
  output logic         field_start,
  output logic         field_load,
  output logic [B-1:0] field_data,
  output logic [2:0]   field_index,
  output logic         sentence_done,
  output logic         checksum_ok,
  output logic         error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_FIELD = 3'd2;
  localparam logic [2:0] S_CKH   = 3'd3;
  localparam logic [2:0] S_CKL   = 3'd4;

  localparam logic [B-1:0] C_DOLLAR = 8'h24;
  localparam logic [B-1:0] C_COMMA  = 8'h2C;
  localparam logic [B-1:0] C_STAR   = 8'h2A;
  localparam logic [B-1:0] C_0      = 8'h30;
  localparam logic [B-1:0] C_9      = 8'h39;
  localparam logic [B-1:0] C_A      = 8'h41;
  localparam logic [B-1:0] C_F      = 8'h46;

  localparam logic [3:0] LEN_MAX = 4'(MAXLEN);
  localparam logic [2:0] LAST_FIELD = 3'd5;
  localparam logic [2:0] HDR_LAST = 3'd5;

  logic [2:0]   state;
  logic [2:0]   hdr_ptr;
  logic [B-1:0] csum;
  logic [3:0]   len;
  logic [3:0]   ck_hi;

  logic [B-1:0] hdr_char;
  logic         hex_vld;
  logic [3:0]   hex_nib;
  logic         in_sentence;

  always_comb begin
    case (hdr_ptr)
      3'd0:    hdr_char = 8'h47;  // G
      3'd1:    hdr_char = 8'h50;  // P
      3'd2:    hdr_char = 8'h5A;  // Z
      3'd3:    hdr_char = 8'h44;  // D
      3'd4:    hdr_char = 8'h41;  // A
      3'd5:    hdr_char = C_COMMA;
      default: hdr_char = 8'h00;
    endcase
  end

  // Only uppercase hex digits are legal in the checksum field.
  always_comb begin
    hex_vld = 1'b0;
    hex_nib = 4'h0;
    if (in_data >= C_0 && in_data <= C_9) begin
      hex_vld = 1'b1;
      hex_nib = in_data[3:0];
    end else if (in_data >= C_A && in_data <= C_F) begin
      hex_vld = 1'b1;
      hex_nib = in_data[3:0] + 4'd9;
    end
  end

  // A '$' only counts as an abort once the header has been accepted.
  assign in_sentence = (state == S_FIELD) || (state == S_CKH) || (state == S_CKL);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      hdr_ptr       <= 3'd0;
      csum          <= '0;
      len           <= 4'd0;
      ck_hi         <= 4'd0;
      field_start   <= 1'b0;
      field_load    <= 1'b0;
      field_data    <= '0;
      field_index   <= 3'd0;
      sentence_done <= 1'b0;
      checksum_ok   <= 1'b0;
      error         <= 1'b0;
    end else begin
      field_start   <= 1'b0;
      field_load    <= 1'b0;
      sentence_done <= 1'b0;
      checksum_ok   <= 1'b0;
      error         <= 1'b0;
      if (in_valid) begin
        field_data <= in_data;
        if (in_data == C_DOLLAR) begin
          error   <= in_sentence;
          state   <= S_HDR;
          hdr_ptr <= 3'd0;
          csum    <= '0;
        end else begin
          case (state)
            S_IDLE: begin
              state <= S_IDLE;
            end
            S_HDR: begin
              if (in_data == hdr_char) begin
                csum <= csum ^ in_data;
                if (hdr_ptr == HDR_LAST) begin
                  field_index <= 3'd0;
                  field_start <= 1'b1;
                  len         <= 4'd0;
                  state       <= S_FIELD;
                end else begin
                  hdr_ptr <= hdr_ptr + 3'd1;
                end
              end else begin
                state <= S_IDLE;
              end
            end
            S_FIELD: begin
              if (in_data == C_COMMA) begin
                if (field_index < LAST_FIELD) begin
                  csum        <= csum ^ in_data;
                  field_index <= field_index + 3'd1;
                  field_start <= 1'b1;
                  len         <= 4'd0;
                end else begin
                  error <= 1'b1;
                  state <= S_IDLE;
                end
              end else if (in_data == C_STAR) begin
                state <= S_CKH;
              end else if (len == LEN_MAX) begin
                error <= 1'b1;
                state <= S_IDLE;
              end else begin
                csum       <= csum ^ in_data;
                field_load <= 1'b1;
                len        <= len + 4'd1;
              end
            end
            S_CKH: begin
              if (hex_vld) begin
                ck_hi <= hex_nib;
                state <= S_CKL;
              end else begin
                error <= 1'b1;
                state <= S_IDLE;
              end
            end
            S_CKL: begin
              if (hex_vld) begin
                sentence_done <= 1'b1;
                checksum_ok   <= ({ck_hi, hex_nib} == csum);
              end else begin
                error <= 1'b1;
              end
              state <= S_IDLE;
            end
            default: begin
              state <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_nmea_zda_framer.sv
// Scoreboarded bench: directed sentences plus random sentences with idle gaps, checked per cycle.
module tb_nmea_zda_framer;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       field_start;
  logic       field_load;
  logic [7:0] field_data;
  logic [2:0] field_index;
  logic       sentence_done;
  logic       checksum_ok;
  logic       error;

  nmea_zda_framer #(.B(8), .MAXLEN(15)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .field_start  (field_start),
    .field_load   (field_load),
    .field_data   (field_data),
    .field_index  (field_index),
    .sentence_done(sentence_done),
    .checksum_ok  (checksum_ok),
    .error        (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       start;
    logic       load;
    logic [7:0] data;
    logic [2:0] idx;
    logic       done;
    logic       ok;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_ok  = 0;
  int   n_nok = 0;
  int   n_err = 0;

  // Reference model: phase 0 idle, 1 header, 2 fields, 3/4 checksum digits.
  int         phase = 0;
  int         m_idx = 0;
  int         m_len = 0;
  int         m_hi  = 0;
  logic [7:0] body_q[$];
  string      hdr_ref = "GPZDA,";

  function automatic bit is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F");
  endfunction

  function automatic int hex_val(input logic [7:0] c);
    return (c <= "9") ? int'(c) - 48 : int'(c) - 65 + 10;
  endfunction

  function automatic logic [7:0] xor_str(input string s);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < s.len(); i++) x ^= s[i];
    return x;
  endfunction

  task automatic model_step(input logic v, input logic [7:0] c, output exp_t e);
    int sum;
    e.start = 0; e.load = 0; e.data = 8'h00; e.done = 0; e.ok = 0; e.err = 0;
    if (v) begin
      if (c == "$") begin
        e.err = (phase >= 2);
        phase = 1;
        body_q.delete();
      end else begin
        case (phase)
          1: begin
            if (c == hdr_ref[body_q.size()]) begin
              body_q.push_back(c);
              if (body_q.size() == 6) begin
                phase = 2; m_idx = 0; m_len = 0; e.start = 1;
              end
            end else phase = 0;
          end
          2: begin
            if (c == ",") begin
              if (m_idx < 5) begin
                m_idx++; m_len = 0; e.start = 1; body_q.push_back(c);
              end else begin
                e.err = 1; phase = 0;
              end
            end else if (c == "*") phase = 3;
            else if (m_len == 15) begin
              e.err = 1; phase = 0;
            end else begin
              m_len++; e.load = 1; e.data = c; body_q.push_back(c);
            end
          end
          3: begin
            if (is_hex(c)) begin m_hi = hex_val(c); phase = 4; end
            else begin e.err = 1; phase = 0; end
          end
          4: begin
            if (is_hex(c)) begin
              sum = 0;
              foreach (body_q[i]) sum = sum ^ int'(body_q[i]);
              e.done = 1;
              e.ok = (m_hi * 16 + hex_val(c)) == sum;
            end else e.err = 1;
            phase = 0;
          end
          default: ;
        endcase
      end
    end
    e.idx = 3'(m_idx);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] c);
    exp_t e;
    @(posedge clock); #2;
    reset = 1'b0; in_valid = 1'b1; in_data = c;
    model_step(1'b1, c, e);
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle();
    exp_t e;
    @(posedge clock); #2;
    reset = 1'b0; in_valid = 1'b0; in_data = 8'($urandom);
    model_step(1'b0, 8'h00, e);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    exp_t e;
    @(posedge clock); #2;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    phase = 0; m_idx = 0; m_len = 0; body_q.delete();
    e = '{start: 0, load: 0, data: 8'h00, idx: 3'd0, done: 0, ok: 0, err: 0};
    exp_q.push_back(e);
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle_cycle();
      send_byte(s[i]);
    end
  endtask

  task automatic drain();
    idle_cycle();
    idle_cycle();
    @(posedge clock); #3;
  endtask

  task automatic run_random(input int n);
    for (int k = 0; k < n; k++) begin
      string body;
      string s;
      int nc;
      int r;
      logic [7:0] cs;
      body = "GPZDA,";
      r = $urandom_range(0, 19);
      if (r == 0) body = "GPGGA,";
      else if (r == 1) body = "GPZDX,";
      nc = $urandom_range(0, 6);
      for (int f = 0; f <= nc; f++) begin
        int len;
        if (f > 0) body = {body, ","};
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 4);
        for (int i = 0; i < len; i++)
          body = {body, $sformatf("%c", 8'h30 + 8'($urandom_range(0, 9)))};
      end
      cs = xor_str(body);
      r = $urandom_range(0, 9);
      if (r == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
      if (r == 1) s = {"$", body, "*", $sformatf("%02x", cs)};
      else if (r == 2) s = {"$", body};
      else s = {"$", body, "*", $sformatf("%02X", cs)};
      if ($urandom_range(0, 4) == 0) s = {s, "\r\n"};
      send_str(s, 1'b1);
      if ($urandom_range(0, 29) == 0) do_reset();
    end
  endtask

  // Monitor: outputs after edge n are compared with the record pushed for the byte driven before edge n.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock); #1;
      if (sentence_done === 1'b1 && checksum_ok === 1'b1) n_ok++;
      if (sentence_done === 1'b1 && checksum_ok !== 1'b1) n_nok++;
      if (error === 1'b1) n_err++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pulses", {28'd0, field_start, field_load, sentence_done, error},
              {28'd0, e.start, e.load, e.done, e.err});
        check("field_index", {29'd0, field_index}, {29'd0, e.idx});
        if (e.load) check("field_data", {24'd0, field_data}, {24'd0, e.data});
        if (e.done) check("checksum_ok", {31'd0, checksum_ok}, {31'd0, e.ok});
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    do_reset();
    send_str("$GPZDA,,,,,,*48", 1'b0);
    send_str("$GPZDA,12,,,,,*4B", 1'b0);
    send_str("$GPZDA,12,,,,,*4C", 1'b0);
    send_str("$GPGGA,1*", 1'b0);
    send_str("$GPZDA,,,,,,*48", 1'b0);
    send_str("$GPZDA,1", 1'b0);
    send_str("$GPZDA,,,,,,*48", 1'b0);
    send_str("$GPZDA,,,,,,,", 1'b0);
    send_str("$GPZDA,1111111111111111", 1'b0);
    send_str("$GPZDA,12", 1'b0);
    do_reset();
    send_str("$GPZDA,,,,,,*48", 1'b0);
    drain();
    check("directed_done_ok", n_ok, 5);
    check("directed_done_bad", n_nok, 1);
    check("directed_error", n_err, 3);

    run_random(300);
    drain();
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
